mult_div_unit: RTL and testbench

Parametrised multi-cycle multiply/divide engine for the multicycle datapath. It serves MULT, DIV and DIVM, and drives the Hi/Lo registers plus the divide-by-zero exception flag. The control unit issues a one-cycle start pulse and waits in a stall state until done is asserted. Each operation has a fixed latency, and signed or unsigned mode is selected per operation.

---
 rtl/mult_div_unit.sv | 154 +++++++++++++++
 tb/tb_mult_div_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide engine: shift-add multiply and restoring divide
// over operand magnitudes, with a final sign-correction step into hi/lo.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FIX    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic               op_q, sa_q, sb_q, dz_q;
    logic [WIDTH-1:0]   mb_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   rem_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               accept;
    logic               busy_nxt, done_nxt, div_zero_nxt;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial, div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = (op && (b == '0)) ? S_FINISH : S_CALC;
            S_CALC:   if (cnt_q == CNT_W'(WIDTH - 1)) state_nxt = S_FIX;
            S_FIX:    state_nxt = S_FINISH;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output decode feeding the registered status flags
    always_comb begin
        accept       = (state == S_IDLE) && start;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        div_zero_nxt = div_zero;
        if (accept) begin
            busy_nxt     = 1'b1;
            div_zero_nxt = 1'b0;
        end
        if (state == S_FINISH) begin
            busy_nxt     = 1'b0;
            done_nxt     = 1'b1;
            div_zero_nxt = dz_q;
        end
    end

    // Per-iteration arithmetic and final sign correction
    always_comb begin
        a_mag     = (a[WIDTH-1] && is_signed) ? -a : a;
        b_mag     = (b[WIDTH-1] && is_signed) ? -b : b;
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mb_q} : '0);
        div_trial = {rem_q, acc_q[WIDTH-1]};
        // trial < 2*divisor, so bit WIDTH of the difference is exactly the borrow
        div_diff  = div_trial - {1'b0, mb_q};
        div_ge    = ~div_diff[WIDTH];
        div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
        prod_fix  = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quo_fix   = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = sa_q ? -rem_q : rem_q;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dz_q     <= 1'b0;
            mb_q     <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
        end else begin
            busy     <= busy_nxt;
            done     <= done_nxt;
            div_zero <= div_zero_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        sa_q  <= a[WIDTH-1] & is_signed;
                        sb_q  <= b[WIDTH-1] & is_signed;
                        dz_q  <= op && (b == '0);
                        mb_q  <= b_mag;
                        acc_q <= {{WIDTH{1'b0}}, a_mag};
                        rem_q <= '0;
                        cnt_q <= '0;
                    end
                end
                S_CALC: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (op_q) begin
                        rem_q              <= div_rem;
                        acc_q[WIDTH-1:0]   <= {acc_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    if (op_q) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized bench for mult_div_unit against a cycle-level behavioural model.
module tb_mult_div_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset, start, op, is_signed;
    logic [W-1:0] a, b;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int errors = 0;
    int checks = 0;
    bit en = 0;

    mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference result {hi, lo} from plain 64-bit arithmetic
    function automatic logic [63:0] ref_calc(input logic o, input logic s,
                                             input logic [W-1:0] x, input logic [W-1:0] y);
        longint xv, yv, r, q, m;
        logic [63:0] res;
        if (s) begin
            xv = longint'(signed'(x));
            yv = longint'(signed'(y));
        end else begin
            xv = longint'({32'b0, x});
            yv = longint'({32'b0, y});
        end
        if (!o) begin
            r   = xv * yv;
            res = r;
        end else begin
            q   = xv / yv;
            m   = xv % yv;
            res = {m[31:0], q[31:0]};
        end
        return res;
    endfunction

    // Behavioural model: timing derived from the accepting edge number
    int           cyc = 0;
    bit           pending = 0, p_dz = 0;
    int           p_t0 = 0;
    logic [63:0]  p_res = '0;
    logic         m_busy = 0, m_done = 0, m_dz = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_done = 0; m_dz = 0; m_hi = '0; m_lo = '0; pending = 0;
        end else begin
            m_done = 0;
            if (pending) begin
                if (!p_dz && cyc == p_t0 + W + 1) begin
                    m_hi = p_res[63:32];
                    m_lo = p_res[31:0];
                end
                if (cyc == p_t0 + (p_dz ? 1 : W + 2)) begin
                    m_done = 1; m_busy = 0; m_dz = p_dz; pending = 0;
                end
            end else if (start) begin
                pending = 1; p_t0 = cyc; m_busy = 1; m_dz = 0;
                p_dz = op && (b == '0);
                if (!p_dz) p_res = ref_calc(op, is_signed, a, b);
            end
        end
        cyc++;
    end

    // Compare process
    always @(negedge clk) begin
        if (en) begin
            chk("busy", {63'b0, busy}, {63'b0, m_busy});
            chk("done", {63'b0, done}, {63'b0, m_done});
            chk("div_zero", {63'b0, div_zero}, {63'b0, m_dz});
            if (!m_busy) begin
                chk("hi", {32'b0, hi}, {32'b0, m_hi});
                chk("lo", {32'b0, lo}, {32'b0, m_lo});
            end
        end
    end

    task automatic wait_done(output int lat, output int bcnt);
        lat = 0; bcnt = 0;
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; op = 1'($urandom); is_signed = 1'($urandom);
        lat = 1;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        chk("done_seen", {63'b0, done}, 64'd1);
    endtask

    task automatic run_op(input logic o, input logic s, input logic [W-1:0] x,
                          input logic [W-1:0] y, output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1; op = o; is_signed = s; a = x; b = y;
        wait_done(lat, bcnt);
    endtask

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] specials [5];
        specials[0] = 32'h0;        specials[1] = 32'h1;
        specials[2] = 32'hFFFFFFFF; specials[3] = 32'h80000000;
        specials[4] = 32'h7FFFFFFF;
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        int lat, bc, dcount;
        logic o, s;
        logic [W-1:0] x, y;
        reset = 1'b1; start = 1'b0; op = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        en = 1;
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_hi", {32'b0, hi}, 64'd0);
        reset = 1'b0;

        // Signed multiply -2 * 3, latency and busy length
        run_op(1'b0, 1'b1, 32'hFFFFFFFE, 32'd3, lat, bc);
        chk("t1_hi", {32'b0, hi}, 64'hFFFFFFFF);
        chk("t1_lo", {32'b0, lo}, 64'hFFFFFFFA);
        chk("t1_model_lo", {32'b0, m_lo}, 64'hFFFFFFFA);
        chk("t1_latency", 64'(lat), 64'd35);
        chk("t1_busy_cycles", 64'(bc), 64'd34);

        run_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
        chk("t2u_hi", {32'b0, hi}, 64'hFFFFFFFE);
        chk("t2u_lo", {32'b0, lo}, 64'h1);
        chk("t2u_model_hi", {32'b0, m_hi}, 64'hFFFFFFFE);
        run_op(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
        chk("t2s_hi", {32'b0, hi}, 64'h0);
        chk("t2s_lo", {32'b0, lo}, 64'h1);

        run_op(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, lat, bc);
        chk("t3s_lo", {32'b0, lo}, 64'hFFFFFFFD);
        chk("t3s_hi", {32'b0, hi}, 64'hFFFFFFFF);
        chk("t3s_model_hi", {32'b0, m_hi}, 64'hFFFFFFFF);
        run_op(1'b1, 1'b0, 32'd100, 32'd7, lat, bc);
        chk("t3u_lo", {32'b0, lo}, 64'd14);
        chk("t3u_hi", {32'b0, hi}, 64'd2);

        // Divide by zero keeps hi/lo from the prior 0x451/0x20 divide
        run_op(1'b1, 1'b0, 32'h451, 32'h20, lat, bc);
        chk("t4_prior_hi", {32'b0, hi}, 64'h11);
        chk("t4_prior_lo", {32'b0, lo}, 64'h22);
        run_op(1'b1, 1'b1, 32'd5, 32'd0, lat, bc);
        chk("t4_latency", 64'(lat), 64'd2);
        chk("t4_div_zero", {63'b0, div_zero}, 64'd1);
        chk("t4_hi", {32'b0, hi}, 64'h11);
        chk("t4_lo", {32'b0, lo}, 64'h22);
        @(negedge clk);
        start = 1'b1; op = 1'b0; is_signed = 1'b0; a = 32'd4; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        chk("t4_dz_cleared", {63'b0, div_zero}, 64'd0);
        wait_done(lat, bc);

        run_op(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, lat, bc);
        chk("t5_lo", {32'b0, lo}, 64'h80000000);
        chk("t5_hi", {32'b0, hi}, 64'h0);
        chk("t5_div_zero", {63'b0, div_zero}, 64'd0);

        // Start during CALC is ignored
        @(negedge clk);
        start = 1'b1; op = 1'b0; is_signed = 1'b0; a = 32'd3; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; a = 32'd7; b = 32'd9;
        wait_done(lat, bc);
        chk("t6_lo", {32'b0, lo}, 64'd15);
        chk("t6_hi", {32'b0, hi}, 64'd0);

        // Reset mid-operation aborts with no done pulse
        @(negedge clk);
        start = 1'b1; op = 1'b1; is_signed = 1'b0; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_busy", {63'b0, busy}, 64'd0);
        chk("t6_rst_hi", {32'b0, hi}, 64'd0);
        chk("t6_rst_lo", {32'b0, lo}, 64'd0);
        reset = 1'b0;
        dcount = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("t6_no_done", 64'(dcount), 64'd0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            o = 1'($urandom); s = 1'($urandom);
            x = rand_operand(); y = rand_operand();
            run_op(o, s, x, y, lat, bc);
            chk("rand_latency", 64'(lat), (o && y == '0) ? 64'd2 : 64'd35);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
